// File: rtl/seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner with per-frame input snapshot,
// per-slot anti-ghosting guard, per-digit blank/blink/dp, registered active-low pins.
module seven_seg_scan #(
  parameter int unsigned DIGIT_TICKS  = 100000,
  parameter int unsigned GUARD        = 4,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  blank,
  input  logic [3:0]  blink_en,
  input  logic [3:0]  dp,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int unsigned TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] GUARD_T   = TW'(GUARD);
  localparam logic [FW-1:0] FC_LAST   = FW'(BLINK_FRAMES - 1);

  logic [TW-1:0] tick;
  logic [1:0]    idx;
  logic [FW-1:0] frame_cnt;
  logic          phase;
  logic          load_flag;
  logic [15:0]   sh_digits;
  logic [3:0]    sh_blank;
  logic [3:0]    sh_blink;
  logic [3:0]    sh_dp;

  logic          wrap;
  logic          boundary;
  logic          load;
  logic          dark;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;
  logic [3:0]    an_dec;

  always_comb begin
    wrap     = (tick == TICK_LAST);
    boundary = wrap && (idx == 2'd3);
    load     = load_flag || boundary;
    nibble   = sh_digits[{idx, 2'b00} +: 4];
    dark     = (tick < GUARD_T) || sh_blank[idx] || (sh_blink[idx] && phase);
    an_dec   = ~(4'b0001 << idx);
    seg_dec  = 7'h7F;
    case (nibble)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0001000;
      4'hB: seg_dec = 7'b0000011;
      4'hC: seg_dec = 7'b1000110;
      4'hD: seg_dec = 7'b0100001;
      4'hE: seg_dec = 7'b0000110;
      4'hF: seg_dec = 7'b0001110;
      default: seg_dec = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick        <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      phase       <= 1'b0;
      load_flag   <= 1'b1;
      sh_digits   <= '0;
      sh_blank    <= '0;
      sh_blink    <= '0;
      sh_dp       <= '0;
      seg         <= '1;
      dp_n        <= 1'b1;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      load_flag <= 1'b0;
      if (load) begin
        sh_digits <= digits;
        sh_blank  <= blank;
        sh_blink  <= blink_en;
        sh_dp     <= dp;
      end
      tick <= wrap ? '0 : tick + 1'b1;
      if (wrap) idx <= idx + 2'd1;
      // Phase flips only on a frame boundary, so a blink never splits a frame.
      if (boundary) begin
        if (frame_cnt == FC_LAST) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      frame_start <= load;
      if (dark) begin
        an   <= '1;
        seg  <= '1;
        dp_n <= 1'b1;
      end else begin
        an   <= an_dec;
        seg  <= seg_dec;
        dp_n <= ~sh_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan at DIGIT_TICKS=8, GUARD=2, BLINK_FRAMES=2;
// pins sampled 1 time unit after each rising edge.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  blank, blink_en, dp;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S6 = 7'b0000010,
                         S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011,
                         SC = 7'b1000110, SD = 7'b0100001, SF = 7'b0001110;
  localparam logic [3:0] AN_OF [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  seven_seg_scan #(.DIGIT_TICKS(8), .GUARD(2), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .digits(digits), .blank(blank), .blink_en(blink_en),
    .dp(dp), .seg(seg), .dp_n(dp_n), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_dark(input string tag, input logic fs);
    chk({tag, " an"}, {12'd0, an}, 16'h000F);
    chk({tag, " seg"}, {9'd0, seg}, 16'h007F);
    chk({tag, " dp_n"}, {15'd0, dp_n}, 16'h0001);
    chk({tag, " frame_start"}, {15'd0, frame_start}, {15'd0, fs});
  endtask

  // One full frame (32 edges) starting from the edge where tick==0, idx==0.
  task automatic scan_frame(input string name, input bit first, input logic [3:0] lit,
                            input logic [27:0] segs, input logic [3:0] dpn,
                            input int chg_k, input logic [15:0] nd, input logic [3:0] nb,
                            input logic [3:0] nbe, input logic [3:0] ndp);
    for (int k = 0; k < 32; k++) begin
      int d, t;
      logic fs;
      string tag;
      step();
      d   = k / 8;
      t   = k % 8;
      fs  = (k == 31) || (first && k == 0);
      tag = $sformatf("%s k%0d", name, k);
      if (lit[d] && t >= 2) begin
        chk({tag, " an"}, {12'd0, an}, {12'd0, AN_OF[d]});
        chk({tag, " seg"}, {9'd0, seg}, {9'd0, segs[7*d +: 7]});
        chk({tag, " dp_n"}, {15'd0, dp_n}, {15'd0, dpn[d]});
        chk({tag, " frame_start"}, {15'd0, frame_start}, {15'd0, fs});
      end else begin
        chk_dark(tag, fs);
      end
      if (k == chg_k) begin
        digits = nd; blank = nb; blink_en = nbe; dp = ndp;
      end
    end
  endtask

  initial begin
    rst = 1'b1; digits = 16'h1234; blank = '0; blink_en = '0; dp = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_dark($sformatf("reset%0d", i), 1'b0);
    end
    rst = 1'b0;

    scan_frame("scan", 1'b1, 4'b1111, {S1, S2, S3, S4}, 4'b1111,
               -1, 16'h1234, 4'b0000, 4'b0000, 4'b0000);
    scan_frame("snap_old", 1'b0, 4'b1111, {S1, S2, S3, S4}, 4'b1111,
               13, 16'hABCD, 4'b0000, 4'b0000, 4'b0000);
    scan_frame("snap_new", 1'b0, 4'b1111, {SA, SB, SC, SD}, 4'b1111,
               5, 16'hABCD, 4'b0100, 4'b0000, 4'b0001);
    scan_frame("blank_dp", 1'b0, 4'b1011, {SA, SB, SC, SD}, 4'b1110,
               20, 16'hABCD, 4'b0000, 4'b1000, 4'b0000);
    scan_frame("blink_f4", 1'b0, 4'b1111, {SA, SB, SC, SD}, 4'b1111,
               -1, 16'hABCD, 4'b0000, 4'b1000, 4'b0000);
    scan_frame("blink_f5", 1'b0, 4'b1111, {SA, SB, SC, SD}, 4'b1111,
               -1, 16'hABCD, 4'b0000, 4'b1000, 4'b0000);
    scan_frame("blink_f6", 1'b0, 4'b0111, {SA, SB, SC, SD}, 4'b1111,
               -1, 16'hABCD, 4'b0000, 4'b1000, 4'b0000);
    scan_frame("blink_f7", 1'b0, 4'b0111, {SA, SB, SC, SD}, 4'b1111,
               -1, 16'hABCD, 4'b0000, 4'b1000, 4'b0000);
    scan_frame("blink_f8", 1'b0, 4'b1111, {SA, SB, SC, SD}, 4'b1111,
               -1, 16'hABCD, 4'b0000, 4'b1000, 4'b0000);

    // Partial frame: reach digit 2 lit, then reset mid-slot.
    for (int k = 0; k <= 18; k++) begin
      step();
      if (k == 5) begin
        digits = 16'h9F06; blink_en = 4'b0000;
      end
    end
    chk("midslot an", {12'd0, an}, 16'h000B);
    chk("midslot seg", {9'd0, seg}, {9'd0, SB});
    rst = 1'b1;
    step();
    chk_dark("rst_mid", 1'b0);
    rst = 1'b0;

    scan_frame("after_rst", 1'b1, 4'b1111, {S9, SF, S0, S6}, 4'b1111,
               -1, 16'h9F06, 4'b0000, 4'b0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
